// File: rtl/light_serialiser.sv
// light_serialiser: captures a 24-bit colour word on request and shifts it out
// MSB first as a pulse-width-coded single-wire LED data stream, then holds the
// line low for a latch gap and pulses done.
module light_serialiser #(
    parameter int unsigned BIT_CYCLES = 10,
    parameter int unsigned T0H        = 3,
    parameter int unsigned T1H        = 7,
    parameter int unsigned RST_CYCLES = 50
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [23:0] light,
    input  logic        send,
    output logic        dout,
    output logic        busy,
    output logic        done
);

    localparam int unsigned WORD_W  = 24;
    localparam int unsigned IDX_W   = 5;
    localparam int unsigned CNT_MAX = (BIT_CYCLES > RST_CYCLES) ? BIT_CYCLES : RST_CYCLES;
    localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BIT   = 2'd1,
        S_LATCH = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [WORD_W-1:0]   shift_q, shift_d;
    logic [IDX_W-1:0]    idx_q,   idx_d;
    logic [CNT_W-1:0]    cnt_q,   cnt_d;
    logic                dout_q,  dout_d;
    logic                busy_q,  busy_d;
    logic                done_q,  done_d;
    logic [CNT_W-1:0]    high_time_c;

    // High time of the bit currently on the wire, selected by the shift MSB
    always_comb begin
        high_time_c = shift_q[WORD_W-1] ? CNT_W'(T1H) : CNT_W'(T0H);
    end

    // Next-state and registered-output logic
    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        dout_d  = 1'b0;
        busy_d  = busy_q;
        done_d  = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                busy_d = 1'b0;
                if (send) begin
                    shift_d = light;
                    idx_d   = '0;
                    cnt_d   = '0;
                    dout_d  = 1'b1;
                    busy_d  = 1'b1;
                    state_d = S_BIT;
                end
            end
            S_BIT: begin
                busy_d = 1'b1;
                if (cnt_q == CNT_W'(BIT_CYCLES - 1)) begin
                    cnt_d   = '0;
                    shift_d = {shift_q[WORD_W-2:0], 1'b0};
                    if (idx_q == IDX_W'(WORD_W - 1)) begin
                        idx_d   = '0;
                        dout_d  = 1'b0;
                        state_d = S_LATCH;
                    end else begin
                        // every bit starts high since both high times are >= 1
                        idx_d  = idx_q + IDX_W'(1);
                        dout_d = 1'b1;
                    end
                end else begin
                    cnt_d  = cnt_q + CNT_W'(1);
                    dout_d = (cnt_d < high_time_c);
                end
            end
            S_LATCH: begin
                busy_d = 1'b1;
                if (cnt_q == CNT_W'(RST_CYCLES - 1)) begin
                    cnt_d   = '0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_IDLE;
            shift_q <= '0;
            idx_q   <= '0;
            cnt_q   <= '0;
            dout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            dout_q  <= dout_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign dout = dout_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: doc/light_serialiser.md
# light_serialiser

Downstream output stage for the 24-bit `light` word produced by the lights selector. On a `send` request it captures the word and serialises it onto a single-wire, pulse-width-coded LED data line, MSB first (R[7] … B[0]). It then holds the line low for a latch gap and reports completion. The block lets the selector's colour output drive an addressable RGB LED directly from the FPGA pin.

## Interface
- `BIT_CYCLES`, default 10: clock cycles per data bit.
- `T0H`, default 3: high-time cycles for a `0` bit.
- `T1H`, default 7: high-time cycles for a `1` bit.
- `RST_CYCLES`, default 50: low latch-gap cycles after the last bit.
- Legal parameter values: 1 ≤ T0H < T1H < BIT_CYCLES, RST_CYCLES ≥ 1.
- `clk` input, 1 bit: the single clock; all logic is on its rising edge.
- `rst` input, 1 bit: reset, synchronous, active-low (0 = reset).
- `light` input, 24 bits: colour word {R[7:0], G[7:0], B[7:0]}, sampled only when a frame is accepted.
- `send` input, 1 bit: frame request level, sampled every cycle while idle.
- `dout` output, 1 bit: serial LED data line, registered.
- `busy` output, 1 bit: high while a frame, including its latch gap, is in progress.
- `done` output, 1 bit: one-cycle pulse at frame completion.

## Operation
- The state machine has three states: IDLE, BIT, LATCH. The reset state is IDLE.
- **IDLE:**
  - Outputs: `dout`=0, `busy`=0.
  - If `send`=1 at an edge, the block loads the shift register with `light`, clears the bit index (5-bit, 0..23) and cycle counter, and sets `busy`=1.
  - It also sets `dout`=1 and moves to BIT.
- **BIT:**
  - The cycle counter runs 0..BIT_CYCLES-1.
  - `dout`=1 while counter < TxH, where TxH = T1H if the current MSB is 1, else T0H. Otherwise `dout`=0.
  - At counter = BIT_CYCLES-1 the block shifts left by 1 and increments the bit index.
  - After bit index 23 completes, it goes to LATCH with the counter cleared.
- **LATCH:**
  - Outputs: `dout`=0, `busy`=1, for RST_CYCLES cycles.
  - Then the block goes to IDLE with `busy`=0 and `done`=1 for exactly one cycle.
- `send` while `busy`=1 is ignored. Requests are not queued.
- Changes on `light` during a frame do not affect the frame in progress.
- If `send` is held high continuously, a new frame is accepted at the first edge in IDLE, i.e. the edge after `done` asserts.
- Reset (`rst`=0 at an edge) overrides everything, mid-frame included. After that edge: IDLE, `dout`=0, `busy`=0, `done`=0, shift register and counters cleared.
- Reset aborts a frame without a `done` pulse.

## Timing
- Reset values: `dout`=0, `busy`=0, `done`=0.
- Accept edge E0 is the edge at which `send`=1 in IDLE. `dout` and `busy` go high in the cycle following E0.
- Bit i (i=0..23) occupies the cycles after edges E0+i·BIT_CYCLES … E0+(i+1)·BIT_CYCLES-1.
- Within bit i, `dout` is high for the first TxH cycles of the bit window.
- The latch gap occupies the cycles after edges E0+24·BIT_CYCLES … E0+24·BIT_CYCLES+RST_CYCLES-1, with `dout`=0 and `busy`=1.
- After edge E0+24·BIT_CYCLES+RST_CYCLES: `busy`=0 and `done`=1, for one cycle.
- With the default parameters:
  - `busy` is high for 290 cycles.
  - The minimum accept-to-accept spacing is 291 cycles.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Test plan
- **Reset:** hold `rst`=0 for 3 cycles with `send`=1 → `dout`=0, `busy`=0, `done`=0 throughout, and no frame starts.
- **All-zero frame:** `light`=24'h000000, single-cycle `send` → 24 pulses, each 3 cycles high and 7 low, then 50 low. `busy` is high for 290 cycles and `done` is high for 1 cycle.
- **Mixed pattern:** `light`=24'hA5FF00 → decoded pulse widths are 7,3,7,3,3,7,3,7, then eight 7s, then eight 3s, in MSB-first order.
- **Ignored inputs:** `send` pulsed again at cycle 100 of the frame, and `light` changed at cycle 50 → the frame is unchanged, with exactly one `done` pulse.
- **Back-to-back:** `send` held high with `light`=24'hFFFFFF → consecutive frames start 291 cycles apart, and each frame has 24 pulses of 7 cycles high.
- **Mid-frame reset:** `rst`=0 for 1 cycle at cycle 120 of a frame → at the next cycle `dout`=0 and `busy`=0, with no `done` pulse. A subsequent `send` starts a clean, full frame.
